edge_filter: RTL

EDGE_FILTER -- requirements
Module: edge_filter

---
 rtl/edge_filter.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/edge_filter.sv
// edge_filter: streaming 3x3 Sobel-style edge filter between two FIFOs.
//
// Pixels are popped from an input FIFO in raster order and pushed to an
// output FIFO in raster order. Output (r,c) is written in the same cycle
// that input index r*IMG_WIDTH+c+L is read (L = IMG_WIDTH+1).
//
// Modes (latched at the first read of each frame):
//   0 : (|Gx|+|Gy|)>>1, saturated
//   1 : binarised mode-0 value against thresh (EDGE_FILTER_THRESH_EN only,
//       otherwise behaves as mode 0 and thresh is ignored)
//   2 : centre pixel pass-through, borders included
//   3 : |Gx|+|Gy|, saturated
//
// Optional feature macro: EDGE_FILTER_THRESH_EN
//
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   mode, thresh      frame configuration
//   in_rd_en          pop request to input FIFO (combinational)
//   in_empty, in_dout input FIFO status / head pixel
//   out_wr_en         push request to output FIFO (combinational)
//   out_full          output FIFO full
//   out_din           output pixel (combinational, valid with out_wr_en)
//   done              one-cycle end-of-frame pulse (registered)
module edge_filter #(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540,
  parameter int unsigned PIXEL_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [PIXEL_W-1:0] thresh,
  output logic               in_rd_en,
  input  logic               in_empty,
  input  logic [PIXEL_W-1:0] in_dout,
  output logic               out_wr_en,
  input  logic               out_full,
  output logic [PIXEL_W-1:0] out_din,
  output logic               done
);

  localparam int unsigned LAG      = IMG_WIDTH + 1;
  localparam int unsigned N_PIX    = IMG_WIDTH * IMG_HEIGHT;
  localparam int unsigned LINE_LEN = 2 * IMG_WIDTH + 3;
  localparam int unsigned CNT_W    = $clog2(N_PIX);
  localparam int unsigned COL_W    = $clog2(IMG_WIDTH);
  localparam int unsigned ROW_W    = $clog2(IMG_HEIGHT);
  localparam int unsigned GRAD_W   = PIXEL_W + 4;

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_rd_cnt;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic [1:0]         r_mode;
  logic [PIXEL_W-1:0] r_line [1:LINE_LEN-1];
  logic [PIXEL_W-1:0] w_tap  [0:LINE_LEN-1];

  logic w_last_rd;
  logic w_last_px;
  logic w_first_rd;
  logic w_shift;
  logic w_border;

`ifdef EDGE_FILTER_THRESH_EN
  logic [PIXEL_W-1:0] r_thresh;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^thresh;
`endif

  assign w_last_rd  = (r_rd_cnt == CNT_W'(N_PIX - 1));
  assign w_last_px  = (r_row == ROW_W'(IMG_HEIGHT - 1)) && (r_col == COL_W'(IMG_WIDTH - 1));
  assign w_first_rd = (r_state == S_FILL) && in_rd_en && (r_rd_cnt == '0);
  // The window advances on every read, and also on flush writes (with a
  // zero pushed in) so the centre tap keeps tracking the output position.
  assign w_shift    = in_rd_en || ((r_state == S_FLUSH) && out_wr_en);
  assign w_border   = (r_row == '0) || (r_row == ROW_W'(IMG_HEIGHT - 1)) ||
                      (r_col == '0) || (r_col == COL_W'(IMG_WIDTH - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_FILL;
    else       r_state <= w_next_state;
  end

  // Next-state and FIFO handshakes
  always_comb begin
    w_next_state = r_state;
    in_rd_en     = 1'b0;
    out_wr_en    = 1'b0;
    case (r_state)
      S_FILL: begin
        in_rd_en = !in_empty;
        if (!in_empty && (r_rd_cnt == CNT_W'(LAG - 1))) w_next_state = S_RUN;
      end
      S_RUN: begin
        in_rd_en  = !in_empty && !out_full;
        out_wr_en = !in_empty && !out_full;
        if (!in_empty && !out_full && w_last_rd) w_next_state = S_FLUSH;
      end
      S_FLUSH: begin
        out_wr_en = !out_full;
        if (!out_full && w_last_px) w_next_state = S_FILL;
      end
      default: w_next_state = S_FILL;
    endcase
    if (reset) begin
      in_rd_en  = 1'b0;
      out_wr_en = 1'b0;
    end
  end

  // Read counter, output position counters and done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_col    <= '0;
      r_row    <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_rd_en) r_rd_cnt <= w_last_rd ? '0 : r_rd_cnt + CNT_W'(1);
      if (out_wr_en) begin
        if (r_col == COL_W'(IMG_WIDTH - 1)) begin
          r_col <= '0;
          r_row <= (r_row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
        if ((r_state == S_FLUSH) && w_last_px) done <= 1'b1;
      end
    end
  end

  // Frame configuration, captured at the first read of a frame
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mode <= 2'd0;
`ifdef EDGE_FILTER_THRESH_EN
      r_thresh <= '0;
`endif
    end else if (w_first_rd) begin
      r_mode <= mode;
`ifdef EDGE_FILTER_THRESH_EN
      r_thresh <= thresh;
`endif
    end
  end

  // Window taps: tap 0 is the pixel being read now, tap k the one read k shifts ago
  always_comb begin
    w_tap[0] = (r_state == S_FLUSH) ? '0 : in_dout;
    for (int k = 1; k < LINE_LEN; k++) w_tap[k] = r_line[k];
  end

  // Line storage shift register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 1; k < LINE_LEN; k++) r_line[k] <= '0;
    end else if (w_shift) begin
      r_line[1] <= w_tap[0];
      for (int k = 2; k < LINE_LEN; k++) r_line[k] <= r_line[k-1];
    end
  end

  function automatic logic signed [GRAD_W-1:0] f_ext(input logic [PIXEL_W-1:0] p);
    f_ext = $signed(GRAD_W'(p));
  endfunction

  function automatic logic [PIXEL_W-1:0] f_sat(input logic [GRAD_W-1:0] v);
    f_sat = (|v[GRAD_W-1:PIXEL_W]) ? '1 : v[PIXEL_W-1:0];
  endfunction

  logic signed [GRAD_W-1:0] w_gx;
  logic signed [GRAD_W-1:0] w_gy;
  logic        [GRAD_W-1:0] w_abs_gx;
  logic        [GRAD_W-1:0] w_abs_gy;
  logic        [GRAD_W-1:0] w_mag;
  logic        [GRAD_W-1:0] w_half;

  // Sobel gradients; older taps sit further up/left in the image
  assign w_gx = (f_ext(w_tap[2*IMG_WIDTH]) + f_ext(w_tap[IMG_WIDTH]) + f_ext(w_tap[IMG_WIDTH]) +
                 f_ext(w_tap[0])) -
                (f_ext(w_tap[2*IMG_WIDTH+2]) + f_ext(w_tap[IMG_WIDTH+2]) + f_ext(w_tap[IMG_WIDTH+2]) +
                 f_ext(w_tap[2]));
  assign w_gy = (f_ext(w_tap[2]) + f_ext(w_tap[1]) + f_ext(w_tap[1]) + f_ext(w_tap[0])) -
                (f_ext(w_tap[2*IMG_WIDTH+2]) + f_ext(w_tap[2*IMG_WIDTH+1]) +
                 f_ext(w_tap[2*IMG_WIDTH+1]) + f_ext(w_tap[2*IMG_WIDTH]));

  assign w_abs_gx = w_gx[GRAD_W-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_abs_gy = w_gy[GRAD_W-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_mag    = w_abs_gx + w_abs_gy;
  assign w_half   = w_mag >> 1;

  // Output select. The flush tail (last row plus last pixel of the row
  // above) is all border, so it comes out as 0 except in pass-through mode.
  always_comb begin
    out_din = '0;
    case (r_mode)
      2'd2: out_din = w_tap[IMG_WIDTH+1];
      2'd3: out_din = w_border ? '0 : f_sat(w_mag);
`ifdef EDGE_FILTER_THRESH_EN
      2'd1: out_din = (w_border || (f_sat(w_half) < r_thresh)) ? '0 : '1;
`endif
      default: out_din = w_border ? '0 : f_sat(w_half);
    endcase
  end

endmodule
